key_scan_encoder: RTL and testbench

KEY_SCAN_ENCODER -- requirements
Module: key_scan_encoder

---
 rtl/key_scan_encoder.sv | 130 +++++++++++++
 tb/tb_key_scan_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_encoder.sv
// Key-matrix change encoder: reports key make/break events as PS/2-style serial frames
// (make = scan code, break = F0 followed by scan code).
module key_scan_encoder #(
  parameter int unsigned HALF_BIT = 1667
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] teclas,
  output logic       ps2_clk,
  output logic       ps2_dat,
  output logic [7:0] CODEWORD,
  output logic       busy
);

  localparam int unsigned CW = $clog2(2 * HALF_BIT);
  localparam logic [CW-1:0] HalfMark = CW'(HALF_BIT);
  localparam logic [CW-1:0] PerLast  = CW'(2 * HALF_BIT - 1);
  // Between F0 and code the gap is shortened by the LOAD and SHIFT-entry cycles,
  // so the lines still stay high for exactly one bit period.
  localparam logic [CW-1:0] GapPfx   = CW'(2 * HALF_BIT - 3);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

  state_e        state;
  logic [7:0]    sync_meta, sync, reported, diff;
  logic [2:0]    idx, low_idx;
  logic          make, pfx_sent, pfx_now;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [10:0]   frame;

  function automatic logic [7:0] scan_code(input logic [2:0] k);
    case (k)
      3'd0:    scan_code = 8'h1C;
      3'd1:    scan_code = 8'h1B;
      3'd2:    scan_code = 8'h23;
      3'd3:    scan_code = 8'h2B;
      3'd4:    scan_code = 8'h34;
      3'd5:    scan_code = 8'h33;
      3'd6:    scan_code = 8'h3B;
      default: scan_code = 8'h42;
    endcase
  endfunction

  always_comb begin
    diff    = sync ^ reported;
    low_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (diff[i]) low_idx = 3'(i);
    end
    frame   = {1'b1, ~^CODEWORD, CODEWORD, 1'b0};
    pfx_now = ~make & ~pfx_sent;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= StIdle;
      sync_meta <= '0;
      sync      <= '0;
      reported  <= '0;
      idx       <= '0;
      make      <= 1'b0;
      pfx_sent  <= 1'b0;
      cnt       <= '0;
      bit_cnt   <= '0;
      CODEWORD  <= '0;
      ps2_clk   <= 1'b1;
      ps2_dat   <= 1'b1;
      busy      <= 1'b0;
    end else begin
      sync_meta <= teclas;
      sync      <= sync_meta;
      unique case (state)
        StIdle: begin
          if (diff != '0) begin
            idx   <= low_idx;
            make  <= sync[low_idx];
            state <= StLoad;
          end
        end
        StLoad: begin
          // A key that already returned to its reported state is a net non-change;
          // drop it before any frame starts. The second frame of a break is never dropped.
          if (!pfx_sent && (sync[idx] != make)) begin
            state <= StIdle;
          end else begin
            CODEWORD <= pfx_now ? 8'hF0 : scan_code(idx);
            bit_cnt  <= '0;
            cnt      <= '0;
            state    <= StShift;
          end
        end
        StShift: begin
          if (cnt == '0) begin
            ps2_clk <= 1'b1;
            if (bit_cnt == 4'd11) begin
              ps2_dat <= 1'b1;
              state   <= StGap;
            end else begin
              ps2_dat <= frame[bit_cnt];
              busy    <= 1'b1;
              cnt     <= cnt + 1'b1;
            end
          end else if (cnt == PerLast) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            if (cnt == HalfMark) ps2_clk <= 1'b0;
            cnt <= cnt + 1'b1;
          end
        end
        StGap: begin
          if (pfx_now && (cnt == GapPfx)) begin
            pfx_sent <= 1'b1;
            state    <= StLoad;
          end else if (!pfx_now && (cnt == PerLast)) begin
            reported[idx] <= make;
            pfx_sent      <= 1'b0;
            busy          <= 1'b0;
            state         <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_encoder.sv
// Directed bench for key_scan_encoder with HALF_BIT = 4: a line monitor decodes frames,
// busy runs and clock-low widths; a vector table plus hand sequences check them.
module tb_key_scan_encoder;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [7:0] teclas   = '0;
  logic       ps2_clk, ps2_dat, busy;
  logic [7:0] CODEWORD;

  key_scan_encoder #(.HALF_BIT(4)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .teclas  (teclas),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .CODEWORD(CODEWORD),
    .busy    (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;

  // Line monitor, sampled on the falling system-clock edge.
  logic [10:0] frames[$];
  int          runs[$];
  logic [10:0] bits;
  int          nbits = 0, low_w = 0, bad_w = 0, busy_cyc = 0, cur_run = 0;
  logic        prev_clk = 1'b1;

  always @(negedge CLOCK_50) begin
    if (!RESET_N) begin
      nbits = 0; low_w = 0; cur_run = 0; prev_clk = 1'b1;
    end else begin
      if (busy) begin
        busy_cyc++; cur_run++;
      end else if (cur_run > 0) begin
        runs.push_back(cur_run); cur_run = 0;
      end
      if (prev_clk && !ps2_clk) begin
        if (nbits < 11) bits[nbits] = ps2_dat;
        nbits++; low_w = 1;
      end else if (!ps2_clk) begin
        low_w++;
      end else if (!prev_clk && ps2_clk) begin
        if (low_w != 4) bad_w++;
        if (nbits == 11) frames.push_back(bits);
        if (nbits >= 11) nbits = 0;
      end
      prev_clk = ps2_clk;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic clear_mon();
    frames.delete(); runs.delete();
    busy_cyc = 0; bad_w = 0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 12 && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    n_cmp++;
    if (quiet < 12) begin
      n_bad++;
      $display("FAIL wait_idle: busy still active after %0d cycles, expected idle", n);
    end
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  typedef struct {
    logic [7:0]      tec;
    int              nfr;
    logic [5:0][7:0] fr;
    int              nev;
    logic [7:0]      rep;
  } vec_t;

  task automatic check_frames(input string tag, input int nfr, input logic [5:0][7:0] fr,
                              input int nev);
    check({tag, "_nframes"}, 32'(frames.size()), 32'(nfr));
    for (int k = 0; k < nfr && k < frames.size(); k++)
      check($sformatf("%s_frame%0d", tag, k), 32'(frames[k]), 32'(mk_frame(fr[k])));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(96 * nfr));
    check({tag, "_busy_runs"}, 32'(runs.size()), 32'(nev));
    check({tag, "_clk_low_width"}, 32'(bad_w), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'h00, 2, {8'h0, 8'h0, 8'h0, 8'h0, 8'h1C, 8'hF0}, 1, 8'h00};
    vecs[1] = '{8'h81, 2, {8'h0, 8'h0, 8'h0, 8'h0, 8'h42, 8'h1C}, 2, 8'h81};
    vecs[2] = '{8'h80, 2, {8'h0, 8'h0, 8'h0, 8'h0, 8'h1C, 8'hF0}, 1, 8'h80};
    vecs[3] = '{8'hA4, 2, {8'h0, 8'h0, 8'h0, 8'h0, 8'h33, 8'h23}, 2, 8'hA4};
    vecs[4] = '{8'h00, 6, {8'h42, 8'hF0, 8'h33, 8'hF0, 8'h23, 8'hF0}, 3, 8'h00};
    vecs[5] = '{8'h00, 0, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 0, 8'h00};
    vecs[6] = '{8'h40, 1, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h3B}, 1, 8'h40};
    vecs[7] = '{8'h48, 1, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h2B}, 1, 8'h48};
    vecs[8] = '{8'h00, 4, {8'h0, 8'h0, 8'h3B, 8'hF0, 8'h2B, 8'hF0}, 2, 8'h00};

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    check("rst_ps2_dat", 32'(ps2_dat), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_codeword", 32'(CODEWORD), 32'h00);
    check("rst_reported", 32'(dut.reported), 32'h00);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    clear_mon();

    // First press: start bit appears after the fourth edge following the sampling edge
    teclas = 8'h01;
    repeat (4) @(negedge CLOCK_50);
    check("lat_busy_early", 32'(busy), 32'd0);
    check("lat_dat_early", 32'(ps2_dat), 32'd1);
    @(negedge CLOCK_50);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_start_bit", 32'(ps2_dat), 32'd0);
    check("lat_clk_high", 32'(ps2_clk), 32'd1);
    wait_idle();
    check_frames("press0", 1, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1C}, 1);
    check("press0_codeword", 32'(CODEWORD), 32'h1C);
    check("press0_reported", 32'(dut.reported), 32'h01);

    // Release of key 0 must be one continuous 192-cycle busy run
    for (int i = 0; i < 9; i++) begin
      clear_mon();
      teclas = vecs[i].tec;
      wait_idle();
      check_frames($sformatf("vec%0d", i), vecs[i].nfr, vecs[i].fr, vecs[i].nev);
      check($sformatf("vec%0d_reported", i), 32'(dut.reported), 32'(vecs[i].rep));
      if (i == 0) check("vec0_run_len", 32'(runs.size() > 0 ? runs[0] : 0), 32'd192);
    end

    // Release key 2 in the middle of its own make frame
    clear_mon();
    teclas = 8'h04;
    wait_busy();
    repeat (20) @(negedge CLOCK_50);
    teclas = 8'h00;
    wait_idle();
    check_frames("midrel", 3, {8'h0, 8'h0, 8'h0, 8'h23, 8'hF0, 8'h23}, 2);
    check("midrel_reported", 32'(dut.reported), 32'h00);

    // One-cycle glitch on key 3
    clear_mon();
    teclas = 8'h08;
    @(negedge CLOCK_50);
    teclas = 8'h00;
    wait_idle();
    check_frames("pulse", 0, '0, 0);
    check("pulse_reported", 32'(dut.reported), 32'h00);

    // Reset during bit 5 of a frame, then re-report
    clear_mon();
    teclas = 8'h10;
    wait_busy();
    repeat (42) @(negedge CLOCK_50);
    RESET_N = 1'b0;
    #1;
    check("abort_ps2_clk", 32'(ps2_clk), 32'd1);
    check("abort_ps2_dat", 32'(ps2_dat), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_codeword", 32'(CODEWORD), 32'h00);
    repeat (3) @(negedge CLOCK_50);
    clear_mon();
    RESET_N = 1'b1;
    wait_idle();
    check_frames("rerep", 1, {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h34}, 1);
    check("rerep_reported", 32'(dut.reported), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
